// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Purpose:
//   Arbitrates the core's instruction-cache and data-cache bus requests onto a
//   single variable-latency memory port. Simultaneous requests are resolved
//   round-robin, with the data side winning the first conflict after reset. A
//   completion is returned to the granted side as a one-cycle ready pulse. A
//   timeout counter forces an error completion if memory never acks, so the
//   pipeline can never hang on a dead memory.
//
// Ports:
//   Clk             in   1   system clock, rising edge
//   Rst             in   1   synchronous reset, active-low
//   Icache_bus_out  in   66  {req, we, addr[31:0], wdata[31:0]}; we is ignored
//   Icache_bus_in   out  33  {ready, rdata[31:0]}
//   Dcache_bus_out  in   66  {req, we, addr[31:0], wdata[31:0]}
//   Dcache_bus_in   out  33  {ready, rdata[31:0]}
//   mem_req         out  1   memory request, held until ack or timeout
//   mem_we          out  1   1 = write, 0 = read
//   mem_addr        out  32  memory address
//   mem_wdata       out  32  memory write data
//   mem_rdata       in   32  memory read data, valid with mem_ack
//   mem_ack         in   1   single-cycle completion from memory
//   o_busy          out  1   high whenever the FSM is not idle
//   o_timeout_err   out  1   sticky timeout flag, cleared only by reset
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [65:0] Icache_bus_out,
    output logic [32:0] Icache_bus_in,
    input  logic [65:0] Dcache_bus_out,
    output logic [32:0] Dcache_bus_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        o_busy,
    output logic        o_timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int unsigned     CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t             state_q, state_d;
    logic               grant_d_q, grant_d_d;   // 1 = data side owns the transaction
    logic               last_d_q, last_d_d;     // 1 = data side was granted last
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [32:0]        ibus_q, ibus_d;
    logic [32:0]        dbus_q, dbus_d;
    logic               busy_q, busy_d;
    logic               terr_q, terr_d;

    logic               req_i, req_d, pick_d;
    logic [32:0]        resp;

    // The instruction cache never writes, so its we bit is deliberately unused.
    logic               unused_i_we;
    assign unused_i_we = Icache_bus_out[64];

    assign req_i = Icache_bus_out[65];
    assign req_d = Dcache_bus_out[65];

    always_comb begin
        state_d     = state_q;
        grant_d_d   = grant_d_q;
        last_d_d    = last_d_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ibus_d      = ibus_q;
        dbus_d      = dbus_q;
        terr_d      = terr_q;
        pick_d      = 1'b0;
        resp        = 33'h0;

        case (state_q)
            S_IDLE: begin
                // On a conflict the side that was not granted last wins.
                pick_d = req_d && (!req_i || !last_d_q);
                if (req_i || req_d) begin
                    grant_d_d   = pick_d;
                    last_d_d    = pick_d;
                    mem_req_d   = 1'b1;
                    mem_we_d    = pick_d ? Dcache_bus_out[64] : 1'b0;
                    mem_addr_d  = pick_d ? Dcache_bus_out[63:32] : Icache_bus_out[63:32];
                    mem_wdata_d = pick_d ? Dcache_bus_out[31:0]  : Icache_bus_out[31:0];
                    cnt_d       = '0;
                    state_d     = S_MEM;
                end
            end

            S_MEM: begin
                cnt_d = cnt_q + 1'b1;
                // An ack in the timeout cycle takes priority: normal completion.
                if (mem_ack) begin
                    resp      = {1'b1, mem_we_q ? 32'h0 : mem_rdata};
                    mem_req_d = 1'b0;
                    state_d   = S_RESP;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    resp      = {1'b1, ERR_DATA};
                    mem_req_d = 1'b0;
                    terr_d    = 1'b1;
                    state_d   = S_RESP;
                end
                if (resp[32]) begin
                    if (grant_d_q) begin
                        dbus_d = resp;
                    end else begin
                        ibus_d = resp;
                    end
                end
            end

            S_RESP: begin
                // One-cycle turnaround lets the requester drop req before
                // IDLE samples it again.
                ibus_d  = 33'h0;
                dbus_d  = 33'h0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q     <= S_IDLE;
            grant_d_q   <= 1'b0;
            last_d_q    <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            ibus_q      <= 33'h0;
            dbus_q      <= 33'h0;
            busy_q      <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_d_q   <= grant_d_d;
            last_d_q    <= last_d_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ibus_q      <= ibus_d;
            dbus_q      <= dbus_d;
            busy_q      <= busy_d;
            terr_q      <= terr_d;
        end
    end

    assign Icache_bus_in = ibus_q;
    assign Dcache_bus_in = dbus_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign o_busy        = busy_q;
    assign o_timeout_err = terr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed bench for mem_bus_arbiter built with an 8-cycle timeout. Inputs are
// driven and outputs sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [65:0] Icache_bus_out;
    logic [32:0] Icache_bus_in;
    logic [65:0] Dcache_bus_out;
    logic [32:0] Dcache_bus_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        o_busy;
    logic        o_timeout_err;

    int checks = 0;
    int passed = 0;

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES(8),
        .ERR_DATA      (32'hDEADBEEF)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Icache_bus_out(Icache_bus_out),
        .Icache_bus_in (Icache_bus_in),
        .Dcache_bus_out(Dcache_bus_out),
        .Dcache_bus_in (Dcache_bus_in),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .o_busy        (o_busy),
        .o_timeout_err (o_timeout_err)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        Icache_bus_out = '0;
        Dcache_bus_out = '0;
        mem_rdata = 32'h0;
        mem_ack = 1'b0;
        step();
        step();
        checks++; if ({mem_req, mem_we, o_busy, o_timeout_err} !== 4'b0)
            $display("FAIL reset_ctrl: got %b want 0000", {mem_req, mem_we, o_busy, o_timeout_err}); else passed++;
        checks++; if ({mem_addr, mem_wdata} !== 64'h0)
            $display("FAIL reset_addr_data: got %h want 0", {mem_addr, mem_wdata}); else passed++;
        checks++; if ({Icache_bus_in, Dcache_bus_in} !== 66'h0)
            $display("FAIL reset_bus_in: got %h want 0", {Icache_bus_in, Dcache_bus_in}); else passed++;
        Rst = 1'b1;
        step();
    endtask

    // D read at 0x100, memory acks two cycles after mem_req rises.
    task automatic test_d_read();
        Dcache_bus_out = {1'b1, 1'b0, 32'h0000_0100, 32'h0};
        step();
        checks++; if ({mem_req, mem_we, o_busy} !== 3'b101)
            $display("FAIL d_read_req: got %b want 101", {mem_req, mem_we, o_busy}); else passed++;
        checks++; if (mem_addr !== 32'h100)
            $display("FAIL d_read_addr: got %h want 00000100", mem_addr); else passed++;
        step();
        step();
        checks++; if (mem_req !== 1'b1 || Dcache_bus_in !== 33'h0)
            $display("FAIL d_read_hold: got req=%b bus=%h want req=1 bus=0", mem_req, Dcache_bus_in); else passed++;
        mem_ack = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        checks++; if (Dcache_bus_in !== 33'h1_1234_5678)
            $display("FAIL d_read_resp: got %h want 112345678", Dcache_bus_in); else passed++;
        checks++; if (Icache_bus_in !== 33'h0 || mem_req !== 1'b0)
            $display("FAIL d_read_other: got ibus=%h req=%b want 0/0", Icache_bus_in, mem_req); else passed++;
        Dcache_bus_out = '0;
        step();
        checks++; if (Dcache_bus_in !== 33'h0 || o_busy !== 1'b0)
            $display("FAIL d_read_pulse_end: got bus=%h busy=%b want 0/0", Dcache_bus_in, o_busy); else passed++;
        step();
    endtask

    // I request with we=1: the write must be forced off.
    task automatic test_i_read_forced();
        Icache_bus_out = {1'b1, 1'b1, 32'h0000_0040, 32'h1111_1111};
        step();
        checks++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h40)
            $display("FAIL i_we_forced: got req/we=%b addr=%h want 10/00000040", {mem_req, mem_we}, mem_addr); else passed++;
        mem_ack = 1'b1;
        mem_rdata = 32'hA5A5_A5A5;
        step();
        mem_ack = 1'b0;
        checks++; if (Icache_bus_in !== 33'h1_A5A5_A5A5 || Dcache_bus_in !== 33'h0)
            $display("FAIL i_resp: got ibus=%h dbus=%h want 1a5a5a5a5/0", Icache_bus_in, Dcache_bus_in); else passed++;
        Icache_bus_out = '0;
        step();
        checks++; if (Icache_bus_in !== 33'h0)
            $display("FAIL i_pulse_end: got %h want 0", Icache_bus_in); else passed++;
        step();
    endtask

    // Both sides request together; the loser stays pending and follows.
    task automatic test_conflict(input bit d_first);
        logic [31:0] a1, a2, r1, r2;
        a1 = d_first ? 32'h400 : 32'h300;
        a2 = d_first ? 32'h300 : 32'h400;
        r1 = d_first ? 32'h0D0D_0D0D : 32'h0101_0101;
        r2 = d_first ? 32'h0101_0101 : 32'h0D0D_0D0D;
        Icache_bus_out = {1'b1, 1'b0, 32'h300, 32'h0};
        Dcache_bus_out = {1'b1, 1'b0, 32'h400, 32'h0};
        step();
        checks++; if (mem_addr !== a1)
            $display("FAIL conflict_first_grant: got %h want %h", mem_addr, a1); else passed++;
        mem_ack = 1'b1;
        mem_rdata = r1;
        step();
        mem_ack = 1'b0;
        checks++; if ((d_first ? Dcache_bus_in : Icache_bus_in) !== {1'b1, r1} ||
                      (d_first ? Icache_bus_in : Dcache_bus_in) !== 33'h0)
            $display("FAIL conflict_first_resp: got ibus=%h dbus=%h", Icache_bus_in, Dcache_bus_in); else passed++;
        if (d_first) Dcache_bus_out = '0; else Icache_bus_out = '0;
        step();
        checks++; if (mem_req !== 1'b0 || o_busy !== 1'b0)
            $display("FAIL conflict_turnaround: got req=%b busy=%b want 0/0", mem_req, o_busy); else passed++;
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== a2)
            $display("FAIL conflict_second_grant: got req=%b addr=%h want 1/%h", mem_req, mem_addr, a2); else passed++;
        mem_ack = 1'b1;
        mem_rdata = r2;
        step();
        mem_ack = 1'b0;
        checks++; if ((d_first ? Icache_bus_in : Dcache_bus_in) !== {1'b1, r2} ||
                      (d_first ? Dcache_bus_in : Icache_bus_in) !== 33'h0)
            $display("FAIL conflict_second_resp: got ibus=%h dbus=%h", Icache_bus_in, Dcache_bus_in); else passed++;
        Icache_bus_out = '0;
        Dcache_bus_out = '0;
        step();
        step();
    endtask

    task automatic test_d_write();
        Dcache_bus_out = {1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_F00D};
        step();
        checks++; if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h200 || mem_wdata !== 32'hCAFE_F00D)
            $display("FAIL d_write_bus: got req/we=%b addr=%h wdata=%h", {mem_req, mem_we}, mem_addr, mem_wdata); else passed++;
        step();
        mem_ack = 1'b1;
        mem_rdata = 32'h5555_5555;
        step();
        mem_ack = 1'b0;
        checks++; if (Dcache_bus_in !== 33'h1_0000_0000)
            $display("FAIL d_write_resp: got %h want 100000000", Dcache_bus_in); else passed++;
        Dcache_bus_out = '0;
        step();
        step();
    endtask

    // Ack lands on the very edge the timeout would fire: ack must win.
    task automatic test_ack_at_timeout();
        Dcache_bus_out = {1'b1, 1'b0, 32'h0000_0700, 32'h0};
        step();
        for (int i = 0; i < 7; i++) step();
        checks++; if (mem_req !== 1'b1)
            $display("FAIL ack_at_to_hold: got req=%b want 1", mem_req); else passed++;
        mem_ack = 1'b1;
        mem_rdata = 32'h7777_7777;
        step();
        mem_ack = 1'b0;
        checks++; if (Dcache_bus_in !== 33'h1_7777_7777 || o_timeout_err !== 1'b0)
            $display("FAIL ack_at_to_resp: got bus=%h err=%b want 177777777/0", Dcache_bus_in, o_timeout_err); else passed++;
        Dcache_bus_out = '0;
        step();
        step();
    endtask

    task automatic test_timeout();
        int n;
        Dcache_bus_out = {1'b1, 1'b0, 32'h0000_0500, 32'h0};
        step();
        n = (mem_req === 1'b1) ? 1 : 0;
        while (mem_req === 1'b1 && n < 20) begin
            step();
            if (mem_req === 1'b1) n++;
        end
        checks++; if (n !== 8)
            $display("FAIL timeout_req_cycles: got %0d want 8", n); else passed++;
        checks++; if (Dcache_bus_in !== 33'h1_DEAD_BEEF || o_timeout_err !== 1'b1)
            $display("FAIL timeout_resp: got bus=%h err=%b want 1deadbeef/1", Dcache_bus_in, o_timeout_err); else passed++;
        Dcache_bus_out = '0;
        step();
        step();
        step();
        checks++; if (o_timeout_err !== 1'b1 || Dcache_bus_in !== 33'h0)
            $display("FAIL timeout_sticky: got err=%b bus=%h want 1/0", o_timeout_err, Dcache_bus_in); else passed++;
    endtask

    task automatic test_reset_mid_txn();
        Icache_bus_out = {1'b1, 1'b0, 32'h0000_0600, 32'h0};
        step();
        step();
        checks++; if (mem_req !== 1'b1)
            $display("FAIL rst_mid_pre: got req=%b want 1", mem_req); else passed++;
        Rst = 1'b0;
        Icache_bus_out = '0;
        step();
        checks++; if ({mem_req, o_busy, o_timeout_err} !== 3'b000)
            $display("FAIL rst_mid_abort: got %b want 000", {mem_req, o_busy, o_timeout_err}); else passed++;
        Rst = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h9999_9999;
        step();
        mem_ack = 1'b0;
        checks++; if ({Icache_bus_in, Dcache_bus_in} !== 66'h0 || {mem_req, o_busy} !== 2'b00)
            $display("FAIL stray_ack: got ibus=%h dbus=%h req/busy=%b", Icache_bus_in, Dcache_bus_in, {mem_req, o_busy}); else passed++;
        step();
        checks++; if ({Icache_bus_in, Dcache_bus_in} !== 66'h0)
            $display("FAIL stray_ack_late: got ibus=%h dbus=%h want 0", Icache_bus_in, Dcache_bus_in); else passed++;
    endtask

    initial begin
        test_reset();
        test_d_read();
        test_i_read_forced();
        test_conflict(1'b1);
        test_d_write();
        test_conflict(1'b0);
        test_ack_at_timeout();
        test_timeout();
        test_reset_mid_txn();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule
